// File: rtl/speck_key_schedule_pkg.sv
// Shared definitions for the SPECK key-schedule block: FSM state encodings,
// SPECK32/64 defaults and the word shift/rotate helpers.
package speck_key_schedule_pkg;

  // SPECK32/64 defaults
  localparam int SPECK32_ALPHA  = 7;
  localparam int SPECK32_BETA   = 2;
  localparam int SPECK32_ROUNDS = 22;

  // Helpers operate on a 64-bit carrier; the caller states the live width.
  localparam int MAX_W = 64;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_EMIT   = 3'd2;
  localparam logic [2:0] ST_UPDATE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Round index as seen on the round_idx port
  typedef logic [4:0] round_idx_t;

  // All-ones mask covering the low 'width' bits
  function automatic logic [MAX_W-1:0] width_mask(input int unsigned width);
    if (width >= MAX_W) return '1;
    return (64'd1 << width) - 64'd1;
  endfunction

  // Logical left shift confined to 'width' bits
  function automatic logic [MAX_W-1:0] shl(input logic [MAX_W-1:0] x,
                                           input int unsigned amt,
                                           input int unsigned width);
    return (x << amt) & width_mask(width);
  endfunction

  // Logical right shift of the low 'width' bits
  function automatic logic [MAX_W-1:0] shr(input logic [MAX_W-1:0] x,
                                           input int unsigned amt,
                                           input int unsigned width);
    return (x & width_mask(width)) >> amt;
  endfunction

  // Wraparound left rotate of a 'width'-bit word
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x,
                                            input int unsigned amt,
                                            input int unsigned width);
    int unsigned a;
    a = amt % width;
    if (a == 0) return x & width_mask(width);
    return shl(x, a, width) | shr(x, width - a, width);
  endfunction

  // Wraparound right rotate, expressed as the complementary left rotate
  function automatic logic [MAX_W-1:0] rotr(input logic [MAX_W-1:0] x,
                                            input int unsigned amt,
                                            input int unsigned width);
    return rotl(x, (width - (amt % width)) % width, width);
  endfunction

endpackage

// File: rtl/speck_key_schedule_round.sv
// One combinational SPECK key-expansion step:
//   l_new  = (k + rotr(l0, ALPHA)) ^ i
//   k_next = rotl(k, BETA) ^ l_new
// Addition wraps modulo 2^WORD_W.
module speck_key_round
  import speck_key_schedule_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int ALPHA  = SPECK32_ALPHA,
  parameter int BETA   = SPECK32_BETA
) (
  input  logic [WORD_W-1:0] k,
  input  logic [WORD_W-1:0] l0,
  input  round_idx_t        i,
  output logic [WORD_W-1:0] k_next,
  output logic [WORD_W-1:0] l_new
);

  logic [WORD_W-1:0] l0_rot;
  logic [WORD_W-1:0] k_rot;

  assign l0_rot = WORD_W'(rotr(64'(l0), ALPHA, WORD_W));
  assign k_rot  = WORD_W'(rotl(64'(k), BETA, WORD_W));

  // Carry out of the add is dropped by the WORD_W-wide result.
  assign l_new  = (k + l0_rot) ^ WORD_W'(i);
  assign k_next = k_rot ^ l_new;

endmodule

// File: rtl/speck_key_schedule.sv
// SPECK key-expansion stage. Latches a master key, then offers one round
// subkey at a time over valid/ready, from round 0 to ROUNDS-1, computing the
// next subkey in a dedicated UPDATE cycle after each acceptance.
module speck_key_schedule
  import speck_key_schedule_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int KEY_WORDS = 4,
  parameter int ROUNDS    = SPECK32_ROUNDS,
  parameter int ALPHA     = SPECK32_ALPHA,
  parameter int BETA      = SPECK32_BETA
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [KEY_WORDS*WORD_W-1:0] master_key,
  input  logic                        start,
  output logic [WORD_W-1:0]           subkey,
  output logic                        subkey_valid,
  input  logic                        subkey_ready,
  output logic [4:0]                  round_idx,
  output logic                        busy,
  output logic                        done
);

  logic [2:0] state_q;
  logic [2:0] state_d;

  // k word plus the l shift register; l_q[0] is the word consumed next.
  logic [WORD_W-1:0]                  k_q;
  logic [KEY_WORDS-2:0][WORD_W-1:0]   l_q;
  round_idx_t                         round_q;

  logic [WORD_W-1:0] k_next;
  logic [WORD_W-1:0] l_new;
  logic              last_round;
  logic              accept;

  assign last_round = (round_q == round_idx_t'(ROUNDS - 1));
  assign accept     = (state_q == ST_EMIT) && subkey_ready;

  speck_key_round #(
    .WORD_W (WORD_W),
    .ALPHA  (ALPHA),
    .BETA   (BETA)
  ) u_round (
    .k      (k_q),
    .l0     (l_q[0]),
    .i      (round_q),
    .k_next (k_next),
    .l_new  (l_new)
  );

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so every path drives state_d; a missing
    // branch would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_EMIT;
      ST_EMIT:   if (accept) state_d = last_round ? ST_DONE : ST_UPDATE;
      ST_UPDATE: state_d = ST_EMIT;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Key datapath: load the master key, then step it once per UPDATE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the key words are reset along with the control state so no part
      // of a previous key can be observed on subkey after reset.
      k_q     <= '0;
      l_q     <= '0;
      round_q <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          k_q     <= master_key[WORD_W-1:0];
          l_q     <= master_key[KEY_WORDS*WORD_W-1:WORD_W];
          round_q <= '0;
        end
        ST_UPDATE: begin
          k_q <= k_next;
          for (int j = 0; j < KEY_WORDS - 2; j++) l_q[j] <= l_q[j+1];
          l_q[KEY_WORDS-2] <= l_new;
          round_q <= round_q + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign subkey       = k_q;
  assign round_idx    = round_q;
  assign subkey_valid = (state_q == ST_EMIT);
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);

endmodule
